// File: rtl/bus_uart_tx.sv
// Bus-mapped UART transmitter with an 8-byte FIFO.
// TXDATA at BASE, STATUS at BASE+1, 8N1 framing.
module bus_uart_tx #(
  parameter logic [29:0] BASE    = 30'h3000_0000,
  parameter int          DIVISOR = 434
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [29:0] address,
  input  logic [31:0] writedata,
  input  logic        writeenable,
  input  logic        readenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        serial_tx
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] RELOAD = 16'(DIVISOR - 1);

  logic [7:0]  mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;
  logic        overflow;
  state_t      state;
  state_t      state_nx;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter;
  logic        pop;
  logic        unused_bits;

  wire full     = (count == 4'd8);
  wire empty    = (count == 4'd0);
  wire tick     = (baud_cnt == 16'd0);
  wire busy     = (state != IDLE);
  wire sel_data = (address == BASE);
  wire sel_stat = (address == BASE + 30'd1);
  wire wr_data  = writeenable && sel_data;
  wire push     = wr_data && !full;

  wire [31:0] status = {24'd0, count, overflow, busy, empty, full};

  assign unused_bits = ^writedata[31:8];

  // FIFO storage; contents are meaningless once count is cleared
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= writedata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      unique case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (wr_data && full)
        overflow <= 1'b1;
      else if (writeenable && sel_stat && writedata[3])
        overflow <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM next state and FIFO pop decision
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: if (tick) state_nx = DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_nx = STOP;
      STOP: begin
        if (tick) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM output: line level per state
  always_comb begin
    serial_tx = 1'b1;
    unique case (state)
      IDLE:    serial_tx = 1'b1;
      START:   serial_tx = 1'b0;
      DATA:    serial_tx = shifter[0];
      STOP:    serial_tx = 1'b1;
      default: serial_tx = 1'b1;
    endcase
  end

  // Bit timer, bit index and shift register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shifter  <= 8'd0;
    end else if (pop) begin
      shifter  <= mem[rd_ptr];
      baud_cnt <= RELOAD;
      bit_idx  <= 3'd0;
    end else if (busy) begin
      if (tick) begin
        baud_cnt <= (state == STOP) ? 16'd0 : RELOAD;
        if (state == DATA) begin
          shifter <= shifter >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  // Registered load response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'd0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= readenable;
      if (readenable) readdata <= sel_stat ? status : 32'd0;
    end
  end

endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 Parameter BASE, default 30'h3000_0000, word address of the TXDATA register; STATUS sits at BASE+1.
REQ-002 Parameter DIVISOR, default 434, clock cycles per serial bit (115200 baud at clk_50); legal range 2..65535.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 address  input  30  CPU word address.
REQ-006 writedata  input  32  CPU store data.
REQ-007 writeenable  input  1  store strobe, one cycle per store.
REQ-008 readenable  input  1  load strobe, one cycle per load.
REQ-009 readdata  output  32  load data, registered.
REQ-010 readdatavalid  output  1  high for one cycle when readdata holds a response.
REQ-011 serial_tx  output  1  UART line, idle high.

Function
REQ-012 The block SHALL hold an 8-entry byte FIFO with a 4-bit count (0..8); full = count 8, empty = count 0.
REQ-013 A write to BASE with FIFO not full SHALL push writedata[7:0]; bits 31:8 are ignored.
REQ-014 A write to BASE with FIFO full SHALL drop the byte and set the sticky overflow flag; full is sampled before any same-cycle pop, so a same-cycle pop never admits the push.
REQ-015 A write to BASE+1 with writedata[3]=1 SHALL clear overflow; all other bits are ignored.
REQ-016 A read at BASE+1 SHALL return, one cycle later with readdatavalid=1: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bits7:4 count, bits31:8 zero.
REQ-017 A read at any other address, BASE included, SHALL return 0 with readdatavalid=1 one cycle later.
REQ-018 Writes to addresses other than BASE and BASE+1 SHALL have no effect.
REQ-019 FSM states are IDLE, START, DATA and STOP; each START, DATA-bit and STOP period lasts exactly DIVISOR cycles, timed by a 16-bit down-counter.
REQ-020 IDLE with FIFO non-empty: pop the head into an 8-bit shifter and enter START on the next edge; serial_tx=0 throughout START.
REQ-021 DATA: shift out 8 bits LSB first, with a 3-bit index tracking the current bit; after bit 7, enter STOP.
REQ-022 STOP: serial_tx=1 for DIVISOR cycles; at its end, if the FIFO is non-empty, pop and go directly to START, otherwise go to IDLE.
REQ-023 Back-to-back frames SHALL therefore start exactly 10*DIVISOR cycles apart.
REQ-024 A push and a pop in the same cycle with the FIFO not full SHALL leave the count unchanged and keep data order.
REQ-025 FIFO pointers are 3 bits and wrap 7->0.

Reset
REQ-026 Asserting reset_n low SHALL immediately force: state IDLE, count 0, pointers 0, overflow 0, baud counter 0, serial_tx=1, readdata=0, readdatavalid=0.
REQ-027 Reset mid-frame SHALL abort the frame, drive serial_tx high asynchronously and discard all FIFO contents.
REQ-028 The first push SHALL be accepted on the first rising edge after reset_n deasserts.

Verification (DIVISOR=4, BASE=30'h100)
REQ-029 Write 32'hFFFF_FFA5 to 30'h100 -> serial_tx is low 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; busy reads 0 afterward.
REQ-030 Write 9 bytes in 9 consecutive cycles -> first is popped at once; count reaches 8; the ninth is dropped only if count is 8 at its cycle; a STATUS read shows the overflow and full bits matching.
REQ-031 Write 8'h55 then 8'h0F back to back -> the second start bit falls exactly 40 cycles after the first; no extra idle cycle between frames.
REQ-032 Read 30'h101 with empty FIFO and idle -> readdata = 32'h0000_0002 and readdatavalid high on the following cycle only.
REQ-033 Set overflow, write 32'h8 to 30'h101 -> the next STATUS read returns bit3 = 0.
REQ-034 Pull reset_n low during DATA bit 3 -> serial_tx=1 the same cycle; after release, STATUS reads 32'h0000_0002.
